// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Brief   : Instruction-ROM address sequencer with run control, a hardware
//           call/return stack and sticky stack fault flags.
// Revision: 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              ADDR_W      = 9,
    parameter int              STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int             c_SP_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic              jmpen,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic [ADDR_W-1:0] jmpaddr,
    output logic [ADDR_W-1:0] addr,
    output logic              running,
    output logic [c_SP_W-1:0] sp,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    // Stack storage is rounded up to a power of two so the index is a plain slice of sp.
    localparam int              c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [c_SP_W-1:0] c_FULL = c_SP_W'(STACK_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [c_SP_W-1:0] r_sp;
    logic              r_running;
    logic              r_ovf;
    logic              r_und;
    logic [ADDR_W-1:0] r_stack [2**c_IDX_W];

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [c_SP_W-1:0] w_sp_dec;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_full     = (r_sp == c_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_sp_dec   = r_sp - 1'b1;
    assign w_addr_inc = r_addr + 1'b1;
    assign w_push     = (r_state == S_RUN) && !halt && advance && !ret && call && !w_full;

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[c_IDX_W-1:0]] <= w_addr_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= RESET_ADDR;
            r_sp      <= '0;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_und     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_addr    <= RESET_ADDR;
                        r_sp      <= '0;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                    end else if (advance) begin
                        if (ret) begin
                            if (w_empty) begin
                                r_state   <= S_FAULT;
                                r_running <= 1'b0;
                                r_und     <= 1'b1;
                            end else begin
                                r_addr <= r_stack[w_sp_dec[c_IDX_W-1:0]];
                                r_sp   <= w_sp_dec;
                            end
                        end else if (call) begin
                            if (w_full) begin
                                r_state   <= S_FAULT;
                                r_running <= 1'b0;
                                r_ovf     <= 1'b1;
                            end else begin
                                r_addr <= jmpaddr;
                                r_sp   <= r_sp + 1'b1;
                            end
                        end else if (jmpen) begin
                            r_addr <= jmpaddr;
                        end else begin
                            r_addr <= w_addr_inc;
                        end
                    end
                end
                S_HALT: begin
                    // A simultaneous halt request keeps the sequencer parked.
                    if (start && !halt) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign addr            = r_addr;
    assign running         = r_running;
    assign sp              = r_sp;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_und;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Directed plus randomized check of pc_sequencer against a
//           queue-based reference model of the sequencer rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int         AW    = 6;
    localparam int         DEPTH = 3;
    localparam logic [5:0] RA    = 6'd60;
    localparam int         MODV  = 1 << AW;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       advance = 1'b0;
    logic       jmpen = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       halt = 1'b0;
    logic [5:0] jmpaddr = '0;
    logic [5:0] addr;
    logic       running;
    logic [1:0] sp;
    logic       stack_overflow;
    logic       stack_underflow;

    pc_sequencer #(
        .ADDR_W     (AW),
        .STACK_DEPTH(DEPTH),
        .RESET_ADDR (RA)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .advance        (advance),
        .jmpen          (jmpen),
        .call           (call),
        .ret            (ret),
        .halt           (halt),
        .jmpaddr        (jmpaddr),
        .addr           (addr),
        .running        (running),
        .sp             (sp),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode names rather than encodings, a queue for the stack.
    typedef enum int {M_IDLE, M_RUN, M_HALT, M_FAULT} mode_t;
    mode_t m_mode;
    int    m_addr;
    int    m_stk[$];
    bit    m_ovf;
    bit    m_und;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_addr = int'(RA);
        m_stk.delete();
        m_ovf  = 1'b0;
        m_und  = 1'b0;
    endfunction

    function automatic void model_step();
        case (m_mode)
            M_IDLE: if (start) begin
                m_mode = M_RUN;
                m_addr = int'(RA);
                m_stk.delete();
            end
            M_RUN: begin
                if (halt) m_mode = M_HALT;
                else if (advance) begin
                    if (ret) begin
                        if (m_stk.size() == 0) begin m_mode = M_FAULT; m_und = 1'b1; end
                        else m_addr = m_stk.pop_back();
                    end else if (call) begin
                        if (m_stk.size() == DEPTH) begin m_mode = M_FAULT; m_ovf = 1'b1; end
                        else begin
                            m_stk.push_back((m_addr + 1) % MODV);
                            m_addr = int'(jmpaddr);
                        end
                    end else if (jmpen) m_addr = int'(jmpaddr);
                    else m_addr = (m_addr + 1) % MODV;
                end
            end
            M_HALT: if (start && !halt) m_mode = M_RUN;
            default: ;
        endcase
    endfunction

    task automatic check_all();
        check_eq("addr", int'(addr), m_addr);
        check_eq("running", int'(running), int'(m_mode == M_RUN));
        check_eq("sp", int'(sp), m_stk.size());
        check_eq("overflow", int'(stack_overflow), int'(m_ovf));
        check_eq("underflow", int'(stack_underflow), int'(m_und));
    endtask

    task automatic cyc(input bit st, input bit adv, input bit jp, input bit cl,
                       input bit rt, input bit hl, input int ja);
        start   = st;
        advance = adv;
        jmpen   = jp;
        call    = cl;
        ret     = rt;
        halt    = hl;
        jmpaddr = 6'(ja);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    // Reset asserted between edges must take effect without waiting for clk.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_addr", int'(addr), int'(RA));
        check_eq("async_running", int'(running), 0);
        check_eq("async_sp", int'(sp), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int rp;
        model_reset();
        sync_reset();

        // Start, wrap through the top of the address space, hold.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 7);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Call, step, then call+ret+jmpen together: only the pop happens.
        cyc(0, 1, 0, 1, 0, 0, 32);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 0, 50);
        // Halt wins over advance; halt+start stays halted; start resumes.
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 9);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        // Nest to full depth, then one more call faults.
        cyc(0, 1, 0, 1, 0, 0, 10);
        cyc(0, 1, 0, 1, 0, 0, 20);
        cyc(0, 1, 0, 1, 0, 0, 30);
        cyc(0, 1, 0, 1, 0, 0, 40);
        cyc(0, 1, 1, 0, 0, 0, 5);
        cyc(1, 1, 0, 0, 1, 0, 5);
        async_reset();
        // Underflow from an empty stack.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        sync_reset();

        rp = 10;
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                sync_reset();
                rp = int'($urandom_range(0, 30));
            end else if (r < 3) begin
                async_reset();
                rp = int'($urandom_range(0, 30));
            end else begin
                cyc($urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 65,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < rp,
                    $urandom_range(0, 99) < 8,
                    int'($urandom_range(0, MODV - 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
